icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Instruction-cache controller sitting directly upstream of the 32-line direct-mapped cache memory (64-bit lines, 8-bit tags).
- Translates fetch addresses into cache read index/tag and returns hit data to fetch.
- On a miss, issues a single outstanding line load to the tagged memory interface, tracks the returned transaction tag, and writes the fill into the cache through its write port.

Parameters:
- NUM_LINES, 32, number of cache lines.
- IDX_BITS, 5, index width (log2 NUM_LINES).
- TAG_BITS, 8, cache tag width.
- MEM_TAG_BITS, 4, memory transaction tag width; value 0 means "no response/no tag".

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- proc2Icache_addr  in  64  fetch address. Bits [2:0] are byte offset, [7:3] are idx, [15:8] are tag; [63:16] are ignored.
- Icache_data_out  out  64  instruction line to fetch.
- Icache_valid_out  out  1  Icache_data_out is valid this cycle.
- rd1_idx  out  IDX_BITS  cache read index.
- rd1_tag  out  TAG_BITS  cache read tag.
- rd1_data  in  64  cache read data.
- rd1_valid  in  1  cache read hit.
- wr1_en  out  1  cache fill write enable.
- wr1_idx  out  IDX_BITS  fill index.
- wr1_tag  out  TAG_BITS  fill tag.
- wr1_data  out  64  fill data.
- proc2mem_command  out  2  0 = NONE, 1 = LOAD; other codes are never driven.
- proc2mem_addr  out  64  line-aligned load address: {48'b0, tag, idx, 3'b000}.
- mem2proc_response  in  MEM_TAG_BITS  nonzero = request accepted, carrying its transaction tag.
- mem2proc_data  in  64  returned line.
- mem2proc_tag  in  MEM_TAG_BITS  tag of the returned data; 0 = none.
- miss_count  out  16  number of misses issued; wraps modulo 2^16.

Behaviour:
- Read path is combinational:
  - rd1_idx = addr[7:3], rd1_tag = addr[15:8].
  - Icache_data_out = rd1_data.
  - Icache_valid_out = rd1_valid, in every state (hit-under-miss allowed).
- Registered state: state, miss_idx, miss_tag, cur_mem_tag, miss_count.
- FSM IDLE:
  - If rd1_valid = 0, latch miss_idx/miss_tag from addr, increment miss_count, go to REQ next cycle.
  - Otherwise stay in IDLE.
- FSM REQ:
  - proc2mem_command = LOAD; proc2mem_addr built from miss_tag and miss_idx.
  - If addr[15:3] no longer equals {miss_tag, miss_idx} (fetch redirected before acceptance), go to IDLE; the command drops next cycle. This takes priority over the acceptance rule below.
  - Else if mem2proc_response != 0, latch cur_mem_tag = mem2proc_response and go to WAIT.
  - Else stay in REQ and re-issue the same request (retry every cycle).
  - mem2proc_tag is ignored in REQ.
- FSM WAIT:
  - proc2mem_command = NONE.
  - When mem2proc_tag == cur_mem_tag (and cur_mem_tag != 0), assert wr1_en for that cycle with wr1_idx = miss_idx, wr1_tag = miss_tag, wr1_data = mem2proc_data. Clear cur_mem_tag and go to IDLE.
  - A fetch-address change during WAIT does not abort; the fill always completes into the latched line.
  - Non-matching tags are ignored.
- Outside the fill cycle: wr1_en = 0, wr1_* hold don't-care values (bench checks wr1_en only), proc2mem_command = NONE except in REQ.
- Latency:
  - Hit: same cycle.
  - Miss: REQ is asserted 1 cycle after the miss is seen.
  - Refetched line: hits the cycle after the fill cycle, because the cache writes on the posedge.
- A new miss seen during WAIT is not registered; it is re-evaluated in IDLE after the fill.
- Reset (reset = 0 at posedge), including mid-miss:
  - state = IDLE, cur_mem_tag = 0, miss_idx = 0, miss_tag = 0, miss_count = 0.
  - Outputs settle to proc2mem_command = NONE and wr1_en = 0.
  - In-flight responses after reset are dropped, since tag 0 never matches.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with a missing address -> proc2mem_command = 0, wr1_en = 0, miss_count = 0; after release the FSM is in IDLE.
- Cold miss and fill:
  - Stimulus: addr = 0x0128 (idx 5, tag 1), rd1_valid = 0; response = 3 on the first REQ cycle; 4 cycles later mem2proc_tag = 3, data = 0xDEADBEEF.
  - Required: the cycle after the miss, command = 1 with addr = 0x0128. In the tag-3 cycle, wr1_en = 1, idx = 5, tag = 1, data = 0xDEADBEEF. miss_count = 1.
- Memory reject/retry:
  - Stimulus: response = 0 for 3 REQ cycles, then 2.
  - Required: command = 1 on all 4 cycles with an unchanged address; WAIT is entered; only tag 2 triggers the fill; tags 1 and 5 are ignored.
- Redirect during REQ: change addr to 0x0200 while in REQ with response = 0 -> command = 0 next cycle, no fill, then a new miss (idx 0, tag 2) is issued and miss_count = 2.
- Hit-under-miss: in WAIT, addr switches to a line with rd1_valid = 1, data 0x42 -> Icache_valid_out = 1, data 0x42 that cycle; the later fill still targets the original idx/tag.
- Reset mid-WAIT: reset = 0 for 1 cycle while in WAIT on tag 4, then mem2proc_tag = 4 -> wr1_en stays 0 and miss_count = 0.

Source files
------------

// File: rtl/icache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_ctrl                                                  |
// | Description : Direct-mapped I-cache controller with combinational hit path |
// |               and a single outstanding line fill to tagged memory.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module icache_ctrl #(
    parameter int NUM_LINES    = 32,
    parameter int IDX_BITS     = 5,
    parameter int TAG_BITS     = 8,
    parameter int MEM_TAG_BITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [63:0]             proc2Icache_addr,
    output logic [63:0]             Icache_data_out,
    output logic                    Icache_valid_out,
    output logic [IDX_BITS-1:0]     rd1_idx,
    output logic [TAG_BITS-1:0]     rd1_tag,
    input  logic [63:0]             rd1_data,
    input  logic                    rd1_valid,
    output logic                    wr1_en,
    output logic [IDX_BITS-1:0]     wr1_idx,
    output logic [TAG_BITS-1:0]     wr1_tag,
    output logic [63:0]             wr1_data,
    output logic [1:0]              proc2mem_command,
    output logic [63:0]             proc2mem_addr,
    input  logic [MEM_TAG_BITS-1:0] mem2proc_response,
    input  logic [63:0]             mem2proc_data,
    input  logic [MEM_TAG_BITS-1:0] mem2proc_tag,
    output logic [15:0]             miss_count
);

    localparam int         PAD_BITS   = 64 - 3 - IDX_BITS - TAG_BITS;
    localparam logic [1:0] C_CMD_NONE = 2'd0;
    localparam logic [1:0] C_CMD_LOAD = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_BITS-1:0]     r_miss_idx;
    logic [TAG_BITS-1:0]     r_miss_tag;
    logic [MEM_TAG_BITS-1:0] r_cur_mem_tag;
    logic [15:0]             r_miss_count;

    logic [IDX_BITS-1:0]     w_addr_idx;
    logic [TAG_BITS-1:0]     w_addr_tag;
    logic                    w_latch_miss;
    logic                    w_accept;
    logic                    w_fill;
    logic                    w_unused;

    assign w_addr_idx = proc2Icache_addr[3 +: IDX_BITS];
    assign w_addr_tag = proc2Icache_addr[3 + IDX_BITS +: TAG_BITS];
    assign w_unused   = ^{proc2Icache_addr[63:3 + IDX_BITS + TAG_BITS],
                          proc2Icache_addr[2:0],
                          (NUM_LINES != (1 << IDX_BITS))};

    // Hit path is purely combinational and stays live during a miss.
    assign rd1_idx          = w_addr_idx;
    assign rd1_tag          = w_addr_tag;
    assign Icache_data_out  = rd1_data;
    assign Icache_valid_out = rd1_valid;

    assign wr1_idx       = r_miss_idx;
    assign wr1_tag       = r_miss_tag;
    assign wr1_data      = mem2proc_data;
    assign proc2mem_addr = {{PAD_BITS{1'b0}}, r_miss_tag, r_miss_idx, 3'b000};
    assign miss_count    = r_miss_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_latch_miss     = 1'b0;
        w_accept         = 1'b0;
        w_fill           = 1'b0;
        proc2mem_command = C_CMD_NONE;
        wr1_en           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rd1_valid) begin
                    w_latch_miss = 1'b1;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                proc2mem_command = C_CMD_LOAD;
                // A redirected fetch abandons the request before acceptance.
                if ({w_addr_tag, w_addr_idx} != {r_miss_tag, r_miss_idx}) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem2proc_response != '0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((r_cur_mem_tag != '0) && (mem2proc_tag == r_cur_mem_tag)) begin
                    w_fill      = 1'b1;
                    wr1_en      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_miss_idx    <= '0;
            r_miss_tag    <= '0;
            r_cur_mem_tag <= '0;
            r_miss_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_miss) begin
                r_miss_idx   <= w_addr_idx;
                r_miss_tag   <= w_addr_tag;
                r_miss_count <= r_miss_count + 16'd1;
            end
            if (w_accept) begin
                r_cur_mem_tag <= mem2proc_response;
            end else if (w_fill) begin
                r_cur_mem_tag <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_icache_ctrl                                               |
// | Description : Directed self-checking bench for icache_ctrl.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_icache_ctrl;

    logic        clock;
    logic        reset;
    logic [63:0] proc2Icache_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [4:0]  rd1_idx;
    logic [7:0]  rd1_tag;
    logic [63:0] rd1_data;
    logic        rd1_valid;
    logic        wr1_en;
    logic [4:0]  wr1_idx;
    logic [7:0]  wr1_tag;
    logic [63:0] wr1_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    icache_ctrl #(
        .NUM_LINES    (32),
        .IDX_BITS     (5),
        .TAG_BITS     (8),
        .MEM_TAG_BITS (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2Icache_addr  (proc2Icache_addr),
        .Icache_data_out   (Icache_data_out),
        .Icache_valid_out  (Icache_valid_out),
        .rd1_idx           (rd1_idx),
        .rd1_tag           (rd1_tag),
        .rd1_data          (rd1_data),
        .rd1_valid         (rd1_valid),
        .wr1_en            (wr1_en),
        .wr1_idx           (wr1_idx),
        .wr1_tag           (wr1_tag),
        .wr1_data          (wr1_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .miss_count        (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock; inputs for the next cycle are then applied away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset             = 1'b0;
        proc2Icache_addr  = 64'h0128;
        rd1_data          = 64'h0;
        rd1_valid         = 1'b0;
        mem2proc_response = 4'd0;
        mem2proc_data     = 64'h0;
        mem2proc_tag      = 4'd0;

        // Reset held two cycles while the address misses
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            check("rst_cmd", {62'd0, proc2mem_command}, 64'd0);
            check("rst_wr1_en", {63'd0, wr1_en}, 64'd0);
            check("rst_miss_count", {48'd0, miss_count}, 64'd0);
        end
        reset     = 1'b1;
        rd1_valid = 1'b1;
        cyc();
        #1;
        check("idle_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("idle_miss_count", {48'd0, miss_count}, 64'd0);

        // Cold miss: idx 5, tag 1
        proc2Icache_addr = 64'h0128;
        rd1_valid        = 1'b0;
        #1;
        check("cold_rd1_idx", {59'd0, rd1_idx}, 64'd5);
        check("cold_rd1_tag", {56'd0, rd1_tag}, 64'd1);
        check("cold_idle_cmd", {62'd0, proc2mem_command}, 64'd0);
        cyc();
        mem2proc_response = 4'd3;
        #1;
        check("cold_req_cmd", {62'd0, proc2mem_command}, 64'd1);
        check("cold_req_addr", proc2mem_addr, 64'h0128);
        check("cold_miss_count", {48'd0, miss_count}, 64'd1);
        cyc();
        mem2proc_response = 4'd0;
        #1;
        check("cold_wait_cmd", {62'd0, proc2mem_command}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("cold_wait_no_fill", {63'd0, wr1_en}, 64'd0);
            cyc();
            #1;
        end
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEADBEEF;
        #1;
        check("cold_fill_en", {63'd0, wr1_en}, 64'd1);
        check("cold_fill_idx", {59'd0, wr1_idx}, 64'd5);
        check("cold_fill_tag", {56'd0, wr1_tag}, 64'd1);
        check("cold_fill_data", wr1_data, 64'hDEADBEEF);
        cyc();
        mem2proc_tag = 4'd0;
        rd1_valid    = 1'b1;
        rd1_data     = 64'hDEADBEEF;
        #1;
        check("refetch_valid", {63'd0, Icache_valid_out}, 64'd1);
        check("refetch_data", Icache_data_out, 64'hDEADBEEF);
        check("refetch_no_fill", {63'd0, wr1_en}, 64'd0);

        // Reject/retry: addr 0x0310 is idx 2, tag 3
        proc2Icache_addr = 64'h0310;
        rd1_valid        = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = (i == 3) ? 4'd2 : 4'd0;
            #1;
            check("retry_cmd", {62'd0, proc2mem_command}, 64'd1);
            check("retry_addr", proc2mem_addr, 64'h0310);
            cyc();
        end
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd1;
        mem2proc_data     = 64'h5555;
        #1;
        check("retry_wait_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("retry_tag1_ignored", {63'd0, wr1_en}, 64'd0);
        cyc();
        mem2proc_tag = 4'd5;
        #1;
        check("retry_tag5_ignored", {63'd0, wr1_en}, 64'd0);
        cyc();
        mem2proc_tag = 4'd2;
        #1;
        check("retry_fill_en", {63'd0, wr1_en}, 64'd1);
        check("retry_fill_idx", {59'd0, wr1_idx}, 64'd2);
        check("retry_fill_tag", {56'd0, wr1_tag}, 64'd3);
        check("retry_miss_count", {48'd0, miss_count}, 64'd2);
        cyc();
        mem2proc_tag = 4'd0;

        // Redirect during REQ: 0x0448 (idx 9, tag 4) abandoned for 0x0200 (idx 0, tag 2)
        proc2Icache_addr = 64'h0448;
        rd1_valid        = 1'b0;
        cyc();
        #1;
        check("redir_req_addr", proc2mem_addr, 64'h0448);
        cyc();
        proc2Icache_addr = 64'h0200;
        #1;
        check("redir_cmd_same_cycle", {62'd0, proc2mem_command}, 64'd1);
        cyc();
        #1;
        check("redir_cmd_dropped", {62'd0, proc2mem_command}, 64'd0);
        check("redir_no_fill", {63'd0, wr1_en}, 64'd0);
        check("redir_count_before", {48'd0, miss_count}, 64'd3);
        cyc();
        #1;
        check("redir_new_cmd", {62'd0, proc2mem_command}, 64'd1);
        check("redir_new_addr", proc2mem_addr, 64'h0200);
        check("redir_count_after", {48'd0, miss_count}, 64'd4);
        mem2proc_response = 4'd6;
        cyc();
        mem2proc_response = 4'd0;

        // Hit-under-miss while waiting on tag 6
        proc2Icache_addr = 64'h0128;
        rd1_valid        = 1'b1;
        rd1_data         = 64'h42;
        #1;
        check("hum_valid", {63'd0, Icache_valid_out}, 64'd1);
        check("hum_data", Icache_data_out, 64'h42);
        check("hum_cmd", {62'd0, proc2mem_command}, 64'd0);
        cyc();
        mem2proc_tag  = 4'd6;
        mem2proc_data = 64'h1111;
        #1;
        check("hum_fill_en", {63'd0, wr1_en}, 64'd1);
        check("hum_fill_idx", {59'd0, wr1_idx}, 64'd0);
        check("hum_fill_tag", {56'd0, wr1_tag}, 64'd2);
        check("hum_fill_data", wr1_data, 64'h1111);
        cyc();
        mem2proc_tag = 4'd0;
        #1;
        check("hum_count", {48'd0, miss_count}, 64'd4);

        // Reset while waiting on tag 4: 0x0A30 is idx 6, tag 0x0A
        proc2Icache_addr = 64'h0A30;
        rd1_valid        = 1'b0;
        cyc();
        mem2proc_response = 4'd4;
        #1;
        check("rstw_req_cmd", {62'd0, proc2mem_command}, 64'd1);
        check("rstw_count", {48'd0, miss_count}, 64'd5);
        cyc();
        mem2proc_response = 4'd0;
        reset             = 1'b0;
        cyc();
        reset        = 1'b1;
        rd1_valid    = 1'b1;
        mem2proc_tag = 4'd4;
        #1;
        check("rstw_no_fill", {63'd0, wr1_en}, 64'd0);
        check("rstw_cmd", {62'd0, proc2mem_command}, 64'd0);
        check("rstw_count_cleared", {48'd0, miss_count}, 64'd0);
        cyc();
        #1;
        check("rstw_still_no_fill", {63'd0, wr1_en}, 64'd0);
        check("rstw_count_held", {48'd0, miss_count}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
